// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// default interrupt vector and the decode-stage NOP used while flushing.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam int          CNT_W              = 2;
  localparam logic [15:0] DEFAULT_IRQ_VECTOR = 16'h0004;
  localparam logic [15:0] NOP_INSTR          = 16'h0000;

endpackage

// File: rtl/flush_counter.sv
// Loadable 2-bit down-counter that paces the flush bubbles after a redirect.
// It saturates at zero; done_o marks the last bubble (count of one).
module flush_counter
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: advances, holds or redirects the PC and squashes
// wrong-path decode slots. Interrupt support is built only with FETCH_IRQ_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int FLUSH_CYCLES = 2
`ifdef FETCH_IRQ_EN
  ,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR = ADDR_W'(DEFAULT_IRQ_VECTOR)
`endif
) (
  input  logic              clk,
  input  logic              reset,
`ifdef FETCH_IRQ_EN
  input  logic              irq,
  output logic              irq_ack,
  output logic [ADDR_W-1:0] epc,
`endif
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              hazard_req,
  input  logic              halt_req,
  input  logic              resume,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              pc_mux_sel,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              stall,
  output logic              stall_pm,
  output logic              flush,
  output logic [1:0]        fsm_state
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 3)) begin : g_bad_flush_cycles
    $error("fetch_sequencer: FLUSH_CYCLES must be in 1..3");
  end

  fetch_state_e      state_q, state_d;
  logic              pc_mux_sel_q, pc_mux_sel_d;
  logic [ADDR_W-1:0] jmp_loc_q, jmp_loc_d;
  logic              stall_q, stall_d;
  logic              stall_pm_q, stall_pm_d;
  logic              flush_q, flush_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_done;
  logic              redirect;
  logic              take_irq;

  flush_counter u_flush_counter (
    .clk        (clk),
    .rst        (reset),
    .load_i     (cnt_load),
    .load_val_i (FLUSH_LOAD),
    .dec_i      (cnt_dec),
    .done_o     (cnt_done)
  );

`ifdef FETCH_IRQ_EN
  logic              irq_mask_q, irq_mask_d;
  logic              irq_ack_q, irq_ack_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              irq_ok;

  // A taken interrupt stays masked until the level has been seen low once.
  assign irq_ok = irq && !irq_mask_q;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (take_irq) begin
      irq_mask_d = 1'b1;
    end else if (!irq) begin
      irq_mask_d = 1'b0;
    end
    irq_ack_d = take_irq;
    epc_d     = take_irq ? fetch_addr : epc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_q <= 1'b0;
      irq_ack_q  <= 1'b0;
      epc_q      <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_ack_q  <= irq_ack_d;
      epc_q      <= epc_d;
    end
  end

  assign irq_ack = irq_ack_q;
  assign epc     = epc_q;
`else
  logic irq_ok;
  logic unused_fetch_addr;

  assign irq_ok            = 1'b0;
  assign unused_fetch_addr = ^fetch_addr;
`endif

  always_comb begin
    state_d      = state_q;
    pc_mux_sel_d = 1'b0;
    jmp_loc_d    = jmp_loc_q;
    stall_d      = 1'b0;
    flush_d      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    redirect     = 1'b0;
    take_irq     = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (branch_req) begin
          redirect = 1'b1;
        end else if (irq_ok) begin
          take_irq = 1'b1;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else if (hazard_req) begin
          state_d = ST_STALL;
          stall_d = 1'b1;
        end
      end
      ST_STALL: begin
        if (branch_req) begin
          redirect = 1'b1;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else if (hazard_req) begin
          stall_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // The decode slot is being squashed, so only a newer redirect matters.
        cnt_dec = 1'b1;
        if (branch_req) begin
          redirect = 1'b1;
        end else if (cnt_done) begin
          state_d = ST_RUN;
        end else begin
          flush_d = 1'b1;
        end
      end
      ST_HALT: begin
        if (irq_ok) begin
          take_irq = 1'b1;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (redirect || take_irq) begin
      state_d      = ST_FLUSH;
      pc_mux_sel_d = 1'b1;
      flush_d      = 1'b1;
      cnt_load     = 1'b1;
`ifdef FETCH_IRQ_EN
      jmp_loc_d    = redirect ? branch_target : IRQ_VECTOR;
`else
      jmp_loc_d    = branch_target;
`endif
    end

    // Program memory lags the PC by one read cycle, except while halted.
    if (state_d == ST_HALT) begin
      stall_d    = 1'b1;
      stall_pm_d = 1'b1;
    end else begin
      stall_pm_d = stall_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_mux_sel_q <= 1'b0;
      jmp_loc_q    <= '0;
      stall_q      <= 1'b0;
      stall_pm_q   <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_mux_sel_q <= pc_mux_sel_d;
      jmp_loc_q    <= jmp_loc_d;
      stall_q      <= stall_d;
      stall_pm_q   <= stall_pm_d;
      flush_q      <= flush_d;
    end
  end

  assign pc_mux_sel = pc_mux_sel_q;
  assign jmp_loc    = jmp_loc_q;
  assign stall      = stall_q;
  assign stall_pm   = stall_pm_q;
  assign flush      = flush_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of per-cycle vectors plus
// hand-written reset and (with FETCH_IRQ_EN) interrupt sequences.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        branch_req;
  logic [15:0] branch_target;
  logic        hazard_req;
  logic        halt_req;
  logic        resume;
  logic [15:0] fetch_addr;
  logic        pc_mux_sel;
  logic [15:0] jmp_loc;
  logic        stall;
  logic        stall_pm;
  logic        flush;
  logic [1:0]  fsm_state;
`ifdef FETCH_IRQ_EN
  logic        irq;
  logic        irq_ack;
  logic [15:0] epc;
`endif

  int n_checks;
  int n_fails;

  fetch_sequencer #(.ADDR_W(16), .FLUSH_CYCLES(2)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef FETCH_IRQ_EN
    .irq           (irq),
    .irq_ack       (irq_ack),
    .epc           (epc),
`endif
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .hazard_req    (hazard_req),
    .halt_req      (halt_req),
    .resume        (resume),
    .fetch_addr    (fetch_addr),
    .pc_mux_sel    (pc_mux_sel),
    .jmp_loc       (jmp_loc),
    .stall         (stall),
    .stall_pm      (stall_pm),
    .flush         (flush),
    .fsm_state     (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [15:0] tgt;
    logic        haz;
    logic        hlt;
    logic        res;
    logic        e_pc;
    logic [15:0] e_jmp;
    logic        e_stall;
    logic        e_pm;
    logic        e_flush;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic pc, input logic [15:0] jl,
                          input logic st, input logic pm, input logic fl, input logic [1:0] fs);
    chk({tag, ".pc_mux_sel"}, {15'd0, pc_mux_sel}, {15'd0, pc});
    chk({tag, ".jmp_loc"},    jmp_loc,             jl);
    chk({tag, ".stall"},      {15'd0, stall},      {15'd0, st});
    chk({tag, ".stall_pm"},   {15'd0, stall_pm},   {15'd0, pm});
    chk({tag, ".flush"},      {15'd0, flush},      {15'd0, fl});
    chk({tag, ".fsm_state"},  {14'd0, fsm_state},  {14'd0, fs});
  endtask

  task automatic idle_inputs();
    branch_req    = 1'b0;
    branch_target = 16'hDEAD;
    hazard_req    = 1'b0;
    halt_req      = 1'b0;
    resume        = 1'b0;
    fetch_addr    = 16'h1111;
`ifdef FETCH_IRQ_EN
    irq           = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    //          br    tgt       haz   hlt   res    pc    jmp       st    pm    fl    state
    vecs[0]  = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[2]  = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[3]  = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[5]  = '{1'b0, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[6]  = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{1'b1, 16'h0100, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[9]  = '{1'b0, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[10] = '{1'b1, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[11] = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[12] = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 16'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[14] = '{1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[15] = '{1'b0, 16'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[16] = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[17] = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[18] = '{1'b0, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[19] = '{1'b1, 16'h0300, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0300, 1'b0, 1'b1, 1'b1, 2'd2};
    vecs[20] = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[21] = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[22] = '{1'b0, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[23] = '{1'b0, 16'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0300, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[24] = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0300, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[25] = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0, 2'd0};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk_outs("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
`ifdef FETCH_IRQ_EN
    chk("reset.irq_ack", {15'd0, irq_ack}, 16'h0000);
    chk("reset.epc", epc, 16'h0000);
`endif
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      branch_req    = vecs[i].br;
      branch_target = vecs[i].tgt;
      hazard_req    = vecs[i].haz;
      halt_req      = vecs[i].hlt;
      resume        = vecs[i].res;
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_jmp, vecs[i].e_stall,
               vecs[i].e_pm, vecs[i].e_flush, vecs[i].e_st);
    end

    // Asynchronous reset in the first flush cycle (counter still at 2).
    idle_inputs();
    branch_req    = 1'b1;
    branch_target = 16'h0abc;
    tick();
    idle_inputs();
    chk_outs("pre_reset", 1'b1, 16'h0abc, 1'b0, 1'b0, 1'b1, 2'd2);
    #1 reset = 1'b1;
    #1;
    chk_outs("async_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    reset = 1'b0;
    tick();
    chk_outs("post_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);

`ifdef FETCH_IRQ_EN
    halt_req = 1'b1;
    tick();
    idle_inputs();
    chk_outs("irq.halt", 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd3);
    irq        = 1'b1;
    fetch_addr = 16'h0012;
    tick();
    chk("irq.take.epc", epc, 16'h0012);
    chk("irq.take.ack", {15'd0, irq_ack}, 16'h0001);
    chk_outs("irq.take", 1'b1, 16'h0004, 1'b0, 1'b1, 1'b1, 2'd2);
    fetch_addr = 16'h0099;
    tick();
    chk("irq.ack_pulse", {15'd0, irq_ack}, 16'h0000);
    chk("irq.epc_hold", epc, 16'h0012);
    tick();
    chk_outs("irq.flush_done", 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk("irq.masked.ack", {15'd0, irq_ack}, 16'h0000);
    chk("irq.masked.state", {14'd0, fsm_state}, 16'h0000);
    irq = 1'b0;
    tick();
    irq           = 1'b1;
    branch_req    = 1'b1;
    branch_target = 16'h0060;
    tick();
    chk("irq.br_wins.ack", {15'd0, irq_ack}, 16'h0000);
    chk("irq.br_wins.jmp", jmp_loc, 16'h0060);
    chk("irq.br_wins.epc", epc, 16'h0012);
    idle_inputs();
    tick();
    tick();
    irq        = 1'b1;
    fetch_addr = 16'h0034;
    tick();
    chk("irq.run.ack", {15'd0, irq_ack}, 16'h0001);
    chk("irq.run.epc", epc, 16'h0034);
    chk("irq.run.jmp", jmp_loc, 16'h0004);
    idle_inputs();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block for the instruction-fetch stage. Each cycle it decides whether the program counter advances, holds, or redirects, and drives the program memory's `pc_mux_sel`, `jmp_loc`, `stall` and `stall_pm` inputs. It also produces a decode-stage `flush` so wrong-path instructions become NOPs. It sits between the execute/hazard logic and the program memory block; all outputs are registered.

## Interface
- `ADDR_W`, 16: instruction address width.
- `FLUSH_CYCLES`, 2: bubbles inserted after a redirect; legal range 1–3.
- `IRQ_VECTOR`, 16'h0004: interrupt handler address. Used only with `FETCH_IRQ_EN`.

- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `branch_req` in 1: taken branch/jump resolved in execute this cycle.
- `branch_target` in ADDR_W: target address, valid with `branch_req`.
- `hazard_req` in 1: load-use hazard; hold fetch for one cycle per asserted cycle.
- `halt_req` in 1: HLT instruction decoded.
- `resume` in 1: leave HALT.
- `fetch_addr` in ADDR_W: program memory `current_address`, used for EPC capture.
- `irq` in 1: level interrupt request. Present only with `FETCH_IRQ_EN`.
- `irq_ack` out 1: one-cycle pulse when the interrupt is taken. Present only with `FETCH_IRQ_EN`.
- `epc` out ADDR_W: return address captured on interrupt. Present only with `FETCH_IRQ_EN`.
- `pc_mux_sel` out 1: select `jmp_loc` as the next fetch address.
- `jmp_loc` out ADDR_W: redirect address.
- `stall` out 1: hold the PC.
- `stall_pm` out 1: hold the instruction output.
- `flush` out 1: squash the decode-stage instruction.
- `fsm_state` out 2: RUN=0, STALL=1, FLUSH=2, HALT=3.

## Operation
- **Reset values.** While `reset` is high, all outputs are 0 and the FSM is in RUN. This includes `jmp_loc`, `epc`, `irq_ack` and the counters. Asserting `reset` mid-operation aborts any flush, stall or halt immediately.
- **Request priority,** evaluated each cycle in every state:
  1. `branch_req`
  2. `irq` (with `FETCH_IRQ_EN`)
  3. `halt_req`
  4. `hazard_req`
- **RUN**
  - `branch_req` → FLUSH. Register `jmp_loc`=`branch_target`, `pc_mux_sel`=1 for exactly one cycle, load flush counter with FLUSH_CYCLES.
  - `halt_req` → HALT.
  - `hazard_req` → STALL.
  - Otherwise stay in RUN with all controls 0.
- **STALL**
  - `stall`=1 for one cycle per `hazard_req` cycle.
  - Return to RUN when `hazard_req` drops.
  - A `branch_req` arriving in STALL wins: deassert `stall` and go to FLUSH.
- **FLUSH**
  - `flush`=1 for FLUSH_CYCLES consecutive cycles, starting in the cycle `pc_mux_sel`=1.
  - The counter decrements each cycle; at 1 → RUN.
  - A new `branch_req` during FLUSH restarts the sequence with the new target and reloads the counter. The last redirect wins.
  - `hazard_req` during FLUSH is ignored, because the instruction is squashed.
- **HALT**
  - `stall`=1 and `stall_pm`=1 continuously; `flush`=0.
  - `resume` → RUN. `stall` drops the cycle after `resume` is sampled.
  - `branch_req` in HALT is ignored. `halt_req` in HALT is a no-op.
- **`stall_pm`.** Outside HALT, `stall_pm` equals `stall` delayed by one cycle, to match the program memory's one-cycle read latency.
- **Arithmetic.** The counter is 2 bits with no wrap; it saturates at 0.

## Timing
- **Request latency.** A request sampled at edge N drives the outputs after edge N; outputs are valid in cycle N+1.
- **Redirect sequence.** For `branch_req` in cycle N:
  - `pc_mux_sel`=1 in cycle N+1 only.
  - `flush`=1 in cycles N+1 … N+FLUSH_CYCLES.
  - `jmp_loc` holds its value until the next redirect.
- **Hazard sequence.** For `hazard_req` in cycles N..N+k−1:
  - `stall`=1 in cycles N+1..N+k.
  - `stall_pm`=1 in cycles N+2..N+k+1.
- **Simultaneous requests.** Only the highest-priority request is acted on; lower-priority requests are dropped, not queued. Requesters re-assert as needed.

## Configuration
- **`FETCH_IRQ_EN` defined:**
  - In RUN or HALT, `irq`=1 with no `branch_req` takes the interrupt.
  - Capture `epc`=`fetch_addr`, set `jmp_loc`=IRQ_VECTOR, pulse `irq_ack` for one cycle, then enter FLUSH exactly as for a branch.
  - A further `irq` is masked until `irq` has been observed low.
  - `irq` in STALL waits until the FSM returns to RUN.
- **`FETCH_IRQ_EN` undefined:** the ports `irq`, `irq_ack` and `epc` do not exist, and no interrupt logic is synthesized.

## Structure
- Shared package `fetch_pkg` holds:
  - the FSM state encoding constants (RUN/STALL/FLUSH/HALT);
  - the default IRQ_VECTOR;
  - the NOP encoding used by decode on `flush`.
- One sub-module, `flush_counter`: a loadable 2-bit down-counter with a `done` output.

## Test plan
- **Reset.** Assert `reset` mid-FLUSH with counter=2 → all outputs 0 in the same cycle; `fsm_state`=0 after release.
- **Branch.** `branch_req`=1, `branch_target`=16'h0040 at cycle 5, FLUSH_CYCLES=2 → `pc_mux_sel`=1 in cycle 6 only, `jmp_loc`=16'h0040, `flush`=1 in cycles 6–7, RUN in cycle 8.
- **Hazard.** `hazard_req` in cycles 3–4 → `stall`=1 in cycles 4–5, `stall_pm`=1 in cycles 5–6.
- **Simultaneous requests.** `branch_req`, `halt_req` and `hazard_req` together → FLUSH taken, no `stall`, no HALT.
- **Back-to-back branches.** Second `branch_req` (target 16'h0080) during FLUSH → `pc_mux_sel` pulses again, `jmp_loc`=16'h0080, `flush` extends a full FLUSH_CYCLES from the new pulse.
- **Halt / interrupt.** `halt_req` → `stall`=`stall_pm`=1 until `resume`. With `FETCH_IRQ_EN`, `irq` in HALT at `fetch_addr`=16'h0012 → `epc`=16'h0012, `jmp_loc`=16'h0004, `irq_ack` one cycle.
